// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the multicycle RISC-V core (riscv_mc).
//   XLEN / XWIDTH : datapath width / register-index width
//   opcode_e      : base RV32I major opcodes (instr[6:0])
//   trace_kind_e  : classification of a retirement trace record
//   trace_rec_t   : one retirement trace record as stored in the trace FIFO
package riscv_pkg;
  localparam int XLEN   = 32;
  localparam int XWIDTH = 5;

  typedef enum logic [6:0] {
    OP_L     = 7'b0000011,
    OP_I     = 7'b0010011,
    OP_AUIPC = 7'b0010111,
    OP_S     = 7'b0100011,
    OP_R     = 7'b0110011,
    OP_LUI   = 7'b0110111,
    OP_B     = 7'b1100011,
    OP_JALR  = 7'b1100111,
    OP_JAL   = 7'b1101111
  } opcode_e;

  typedef enum logic [1:0] {
    K_NONE  = 2'd0,
    K_REG   = 2'd1,
    K_LOAD  = 2'd2,
    K_STORE = 2'd3
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e         kind;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     instr;
    logic [XWIDTH-1:0]   rd;
    logic [XLEN-1:0]     data;
    logic [XLEN-1:0]     addr;
  } trace_rec_t;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } rtb_state_e;
endpackage

// File: rtl/retire_trace_buffer_fifo.sv
// trace_fifo: show-ahead FIFO of trace_rec_t.
//   clk_i, rstn_i (async, active low)
//   push_i/din_i : write; accepted when not full, or when full with a pop
//   pop_i        : consume head; ignored while empty
//   dout_o       : head record (all zeros while empty)
//   full_o, empty_o, count_o : status, count_o exact 0..DEPTH
import riscv_pkg::*;

module trace_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       push_i,
  input  trace_rec_t din_i,
  input  logic       pop_i,
  output trace_rec_t dout_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [AW:0] count_o
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  trace_rec_t        mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign count_o = cnt_q;

  // A pop frees the slot the push writes into, so full+pop still accepts.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign cnt_d   = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};

  // Zeroed while empty so stale storage never reaches the port after reset.
  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: retirement-trace capture for riscv_mc.
//   Classifies each retired instruction (REG/LOAD/STORE/NONE), buffers it in
//   a show-ahead FIFO drained over trc_valid_o/trc_ready_i. An all-zero
//   instruction starts a drain; halt_o rises once the FIFO is empty.
// Ports:
//   clk_i, rstn_i (async, active low)
//   ret_*  : retirement record input, ret_valid_i is a one-cycle pulse
//   trc_*  : head record + valid/ready handshake
//   count_o, drop_cnt_o (saturating), overflow_o (sticky), halt_o
// Build option:
//   RETIRE_TRACE_SKIP_NONE_EN - NONE-kind records are never pushed (and never
//   counted as drops); otherwise every retired instruction is recorded.
import riscv_pkg::*;

module retire_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              ret_valid_i,
  input  logic [XLEN-1:0]   ret_pc_i,
  input  logic [XLEN-1:0]   ret_instr_i,
  input  logic [XLEN-1:0]   ret_result_i,
  input  logic [XLEN-1:0]   ret_load_addr_i,
  input  logic [XLEN-1:0]   ret_mem_data_i,
  output logic              trc_valid_o,
  input  logic              trc_ready_i,
  output logic [1:0]        trc_kind_o,
  output logic [XLEN-1:0]   trc_pc_o,
  output logic [XLEN-1:0]   trc_instr_o,
  output logic [XWIDTH-1:0] trc_rd_o,
  output logic [XLEN-1:0]   trc_data_o,
  output logic [XLEN-1:0]   trc_addr_o,
  output logic [CW-1:0]     count_o,
  output logic [DROP_W-1:0] drop_cnt_o,
  output logic              overflow_o,
  output logic              halt_o
);
  rtb_state_e          state_q;
  logic                halt_q, ovf_q;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
  trace_rec_t          rec, head;
  logic                full, empty, push, pop, drop, halt_seen, eligible;
  logic [CW-1:0]       fifo_cnt;
  logic [6:0]          opc;
  logic [XWIDTH-1:0]   rd;

  assign opc = ret_instr_i[6:0];
  assign rd  = ret_instr_i[11:7];

  always_comb begin
    rec       = '0;
    rec.kind  = K_NONE;
    rec.pc    = ret_pc_i;
    rec.instr = ret_instr_i;
    case (opc)
      OP_S: begin
        rec.kind = K_STORE;
        rec.addr = ret_result_i;
        rec.data = ret_mem_data_i;
      end
      OP_L: if (rd != '0) begin
        rec.kind = K_LOAD;
        rec.rd   = rd;
        rec.data = ret_result_i;
        rec.addr = ret_load_addr_i;
      end
      OP_R, OP_I, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: if (rd != '0) begin
        rec.kind = K_REG;
        rec.rd   = rd;
        rec.data = ret_result_i;
      end
      default: ;
    endcase
  end

`ifdef RETIRE_TRACE_SKIP_NONE_EN
  assign eligible = (rec.kind != K_NONE);
`else
  assign eligible = 1'b1;
`endif

  assign halt_seen = (state_q == S_RUN) && ret_valid_i && (ret_instr_i == '0);
  assign push      = (state_q == S_RUN) && ret_valid_i && (ret_instr_i != '0) && eligible;
  assign pop       = trc_valid_o && trc_ready_i;
  assign drop      = push && full && !pop;

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .din_i   (rec),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_cnt)
  );

  assign trc_valid_o = !empty;
  assign trc_kind_o  = head.kind;
  assign trc_pc_o    = head.pc;
  assign trc_instr_o = head.instr;
  assign trc_rd_o    = head.rd;
  assign trc_data_o  = head.data;
  assign trc_addr_o  = head.addr;
  assign count_o     = fifo_cnt;
  assign drop_cnt_o  = drop_cnt_q;
  assign overflow_o  = ovf_q;
  assign halt_o      = halt_q;

  // Emptiness is checked every DRAIN cycle, including the entry cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_RUN;
      halt_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RUN:   if (halt_seen) state_q <= S_DRAIN;
        S_DRAIN: if (fifo_cnt == '0) begin
          state_q <= S_HALTED;
          halt_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign drop_cnt_d = (drop && (drop_cnt_q != {DROP_W{1'b1}})) ? drop_cnt_q + DROP_W'(1)
                                                                : drop_cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      if (drop) ovf_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_retire_trace_buffer.sv
`timescale 1ns/1ps
module tb_retire_trace_buffer;
  import riscv_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DROP_W = 16;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic              ret_valid_i = 1'b0;
  logic [XLEN-1:0]   ret_pc_i = '0, ret_instr_i = '0, ret_result_i = '0;
  logic [XLEN-1:0]   ret_load_addr_i = '0, ret_mem_data_i = '0;
  logic              trc_ready_i = 1'b0;
  logic              trc_valid_o;
  logic [1:0]        trc_kind_o;
  logic [XLEN-1:0]   trc_pc_o, trc_instr_o, trc_data_o, trc_addr_o;
  logic [XWIDTH-1:0] trc_rd_o;
  logic [CW-1:0]     count_o;
  logic [DROP_W-1:0] drop_cnt_o;
  logic              overflow_o, halt_o;

  retire_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .ret_valid_i(ret_valid_i), .ret_pc_i(ret_pc_i),
    .ret_instr_i(ret_instr_i), .ret_result_i(ret_result_i),
    .ret_load_addr_i(ret_load_addr_i), .ret_mem_data_i(ret_mem_data_i),
    .trc_valid_o(trc_valid_o), .trc_ready_i(trc_ready_i), .trc_kind_o(trc_kind_o),
    .trc_pc_o(trc_pc_o), .trc_instr_o(trc_instr_o), .trc_rd_o(trc_rd_o),
    .trc_data_o(trc_data_o), .trc_addr_o(trc_addr_o), .count_o(count_o),
    .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o), .halt_o(halt_o)
  );

  always #5 clk_i = ~clk_i;

  int vecs = 0;
  int errs = 0;
  trace_rec_t q[$];

  // Reference classification, written from the opcode table directly.
  function automatic trace_rec_t model(input logic [31:0] pc, instr, res, la, md);
    trace_rec_t r;
    logic [4:0] rd;
    logic [6:0] op;
    rd = instr[11:7];
    op = instr[6:0];
    r = '0;
    r.kind = K_NONE;
    r.pc = pc;
    r.instr = instr;
    if (op == 7'h23) begin
      r.kind = K_STORE; r.addr = res; r.data = md;
    end else if (rd != 5'd0) begin
      if (op == 7'h03) begin
        r.kind = K_LOAD; r.rd = rd; r.data = res; r.addr = la;
      end else if (op inside {7'h33, 7'h13, 7'h6f, 7'h67, 7'h17, 7'h37}) begin
        r.kind = K_REG; r.rd = rd; r.data = res;
      end
    end
    return r;
  endfunction

  function automatic bit pushable(input trace_kind_e k);
`ifdef RETIRE_TRACE_SKIP_NONE_EN
    return k != K_NONE;
`else
    return (k == k);
`endif
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rd, 7'h13};
  endfunction

  function automatic trace_rec_t head();
    trace_rec_t r;
    r.kind  = trace_kind_e'(trc_kind_o);
    r.pc    = trc_pc_o;
    r.instr = trc_instr_o;
    r.rd    = trc_rd_o;
    r.data  = trc_data_o;
    r.addr  = trc_addr_o;
    return r;
  endfunction

  // Drive a retirement record now; queue its expected trace if it should land.
  task automatic set_ret(input logic [31:0] pc, instr, res, la, md, input bit keep);
    trace_rec_t r;
    ret_valid_i = 1'b1;
    ret_pc_i = pc; ret_instr_i = instr; ret_result_i = res;
    ret_load_addr_i = la; ret_mem_data_i = md;
    r = model(pc, instr, res, la, md);
    if (keep && instr != 32'h0 && pushable(r.kind)) q.push_back(r);
  endtask

  task automatic pulse(input logic [31:0] pc, instr, res, la, md, input bit keep);
    @(posedge clk_i); #1;
    set_ret(pc, instr, res, la, md, keep);
    @(posedge clk_i); #1;
    ret_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    ret_valid_i = 1'b0;
    trc_ready_i = 1'b0;
    q.delete();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_i);
    vecs++; if (trc_valid_o !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", trc_valid_o); end
    vecs++; if (count_o !== '0) begin errs++; $display("FAIL reset_count got %0d want 0", count_o); end
    vecs++; if (drop_cnt_o !== '0) begin errs++; $display("FAIL reset_drop got %0d want 0", drop_cnt_o); end
    vecs++; if (overflow_o !== 1'b0) begin errs++; $display("FAIL reset_ovf got %b want 0", overflow_o); end
    vecs++; if (halt_o !== 1'b0) begin errs++; $display("FAIL reset_halt got %b want 0", halt_o); end
    vecs++; if (head() !== trace_rec_t'('0)) begin errs++; $display("FAIL reset_head got %h want 0", head()); end
  endtask

  task automatic test_classify();
    logic [31:0] tv [4][5];
    int n;
    tv[0] = '{32'h0, 32'h00700293, 32'h7, 32'h0, 32'h0};        // addi x5,x0,7
    tv[1] = '{32'h4, 32'h00502423, 32'h8, 32'h0, 32'h7};        // sw x5,8(x0)
    tv[2] = '{32'h8, 32'h00000463, 32'h0, 32'h0, 32'h0};        // beq
    tv[3] = '{32'hc, 32'h0040a183, 32'hdead_beef, 32'h44, 32'h0}; // lw x3,4(x1)
    for (int i = 0; i < 4; i++) begin
      n = q.size();
      pulse(tv[i][0], tv[i][1], tv[i][2], tv[i][3], tv[i][4], 1'b1);
      @(negedge clk_i);
      if (q.size() > n) begin
        vecs++;
        if (trc_valid_o !== 1'b1 || count_o !== CW'(1) || head() !== q[0]) begin
          errs++;
          $display("FAIL classify[%0d] got v=%b cnt=%0d %h want v=1 cnt=1 %h",
                   i, trc_valid_o, count_o, head(), q[0]);
        end
        @(posedge clk_i); #1; trc_ready_i = 1'b1;
        @(posedge clk_i); #1; trc_ready_i = 1'b0;
        void'(q.pop_front());
      end else begin
        vecs++;
        if (trc_valid_o !== 1'b0) begin errs++; $display("FAIL classify_skip[%0d] got v=%b want 0", i, trc_valid_o); end
      end
    end
  endtask

  task automatic test_overflow();
    bit done;
    trc_ready_i = 1'b0;
    for (int i = 0; i < 6; i++)
      pulse(32'h100 + 32'(i*4), addi(5'(i+1), 12'(i+10)), 32'(i+10), 32'h0, 32'h0, i < 4);
    @(negedge clk_i);
    vecs++; if (count_o !== CW'(4)) begin errs++; $display("FAIL ovf_count got %0d want 4", count_o); end
    vecs++; if (drop_cnt_o !== DROP_W'(2)) begin errs++; $display("FAIL ovf_drop got %0d want 2", drop_cnt_o); end
    vecs++; if (overflow_o !== 1'b1) begin errs++; $display("FAIL ovf_sticky got %b want 1", overflow_o); end
    // push coinciding with a pop while full
    @(posedge clk_i); #1;
    trc_ready_i = 1'b1;
    set_ret(32'h200, addi(5'd9, 12'd99), 32'd99, 32'h0, 32'h0, 1'b1);
    @(negedge clk_i);
    vecs++; if (head() !== q[0]) begin errs++; $display("FAIL ovf_pp_head got %h want %h", head(), q[0]); end
    void'(q.pop_front());
    @(posedge clk_i); #1;
    ret_valid_i = 1'b0;
    trc_ready_i = 1'b0;
    @(negedge clk_i);
    vecs++; if (count_o !== CW'(4)) begin errs++; $display("FAIL ovf_pp_count got %0d want 4", count_o); end
    vecs++; if (drop_cnt_o !== DROP_W'(2)) begin errs++; $display("FAIL ovf_pp_drop got %0d want 2", drop_cnt_o); end
    @(posedge clk_i); #1; trc_ready_i = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk_i);
      if (trc_valid_o) begin
        vecs++;
        if (head() !== q[0]) begin errs++; $display("FAIL ovf_drain got %h want %h", head(), q[0]); end
        void'(q.pop_front());
      end
      done = (q.size() == 0);
    end
    @(posedge clk_i); #1; trc_ready_i = 1'b0;
    vecs++; if (q.size() != 0) begin errs++; $display("FAIL ovf_drain_timeout got %0d left want 0", q.size()); end
    @(negedge clk_i);
    vecs++; if (count_o !== '0) begin errs++; $display("FAIL ovf_empty got %0d want 0", count_o); end
  endtask

  task automatic test_backpressure();
    int sent;
    bit stall;
    trace_rec_t prev;
    logic [6:0] ops [10];
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h17, 7'h37, 7'h0b};
    sent = 0;
    stall = 1'b0;
    prev = '0;
    for (int c = 0; c < 3000 && (sent < 100 || q.size() > 0); c++) begin
      @(posedge clk_i); #1;
      ret_valid_i = 1'b0;
      trc_ready_i = ($urandom_range(0, 99) < 55);
      if (sent < 100 && count_o < CW'(DEPTH) && $urandom_range(0, 2) != 0) begin
        r = $urandom();
        set_ret(32'h1000 + 32'(sent*4), {r[31:7], ops[$urandom_range(0, 9)]},
                $urandom(), $urandom(), $urandom(), 1'b1);
        sent++;
      end
      @(negedge clk_i);
      if (stall) begin
        vecs++;
        if (trc_valid_o !== 1'b1 || head() !== prev) begin
          errs++; $display("FAIL bp_stable got v=%b %h want v=1 %h", trc_valid_o, head(), prev);
        end
      end
      if (trc_valid_o && trc_ready_i) begin
        vecs++;
        if (q.size() == 0) begin
          errs++; $display("FAIL bp_extra got %h want none", head());
        end else begin
          if (head() !== q[0]) begin errs++; $display("FAIL bp_order got %h want %h", head(), q[0]); end
          void'(q.pop_front());
        end
      end
      stall = trc_valid_o && !trc_ready_i;
      prev = head();
    end
    @(posedge clk_i); #1;
    ret_valid_i = 1'b0;
    trc_ready_i = 1'b0;
    vecs++;
    if (sent != 100 || q.size() != 0) begin
      errs++; $display("FAIL bp_timeout got sent=%0d left=%0d want sent=100 left=0", sent, q.size());
    end
  endtask

  task automatic test_halt();
    bit seen;
    do_reset();
    for (int i = 0; i < 3; i++)
      pulse(32'h300 + 32'(i*4), addi(5'(i+2), 12'(i+1)), 32'(i+1), 32'h0, 32'h0, 1'b1);
    pulse(32'h30c, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    pulse(32'h310, addi(5'd7, 12'd5), 32'd5, 32'h0, 32'h0, 1'b0);  // ignored in DRAIN
    @(negedge clk_i);
    vecs++; if (count_o !== CW'(3)) begin errs++; $display("FAIL halt_count got %0d want 3", count_o); end
    vecs++; if (drop_cnt_o !== '0) begin errs++; $display("FAIL halt_drop got %0d want 0", drop_cnt_o); end
    vecs++; if (halt_o !== 1'b0) begin errs++; $display("FAIL halt_early got %b want 0", halt_o); end
    @(posedge clk_i); #1; trc_ready_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk_i);
      if (trc_valid_o) begin
        vecs++;
        if (q.size() == 0 || head() !== q[0]) begin errs++; $display("FAIL halt_drain got %h want %h", head(), q[0]); end
        if (q.size() != 0) void'(q.pop_front());
      end else if (count_o == '0) begin
        vecs++; if (halt_o !== 1'b0) begin errs++; $display("FAIL halt_at_zero got %b want 0", halt_o); end
        @(negedge clk_i);
        vecs++; if (halt_o !== 1'b1) begin errs++; $display("FAIL halt_rise got %b want 1", halt_o); end
        seen = 1'b1;
      end
    end
    vecs++; if (!seen || q.size() != 0) begin errs++; $display("FAIL halt_timeout got seen=%b left=%0d want 1/0", seen, q.size()); end
    @(posedge clk_i); #1; trc_ready_i = 1'b0;
    pulse(32'h400, addi(5'd8, 12'd3), 32'd3, 32'h0, 32'h0, 1'b0);
    @(negedge clk_i);
    vecs++;
    if (trc_valid_o !== 1'b0 || count_o !== '0 || halt_o !== 1'b1 || drop_cnt_o !== '0) begin
      errs++; $display("FAIL halt_ignore got v=%b cnt=%0d halt=%b drop=%0d want 0/0/1/0",
                       trc_valid_o, count_o, halt_o, drop_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++)
      pulse(32'h500 + 32'(i*4), addi(5'(i+1), 12'(i)), 32'(i), 32'h0, 32'h0, i < 4);
    @(negedge clk_i);
    vecs++;
    if (count_o !== CW'(4) || drop_cnt_o !== DROP_W'(1)) begin
      errs++; $display("FAIL rmid_pre got cnt=%0d drop=%0d want 4/1", count_o, drop_cnt_o);
    end
    #2 rstn_i = 1'b0;
    #1;
    vecs++;
    if (trc_valid_o !== 1'b0 || count_o !== '0 || drop_cnt_o !== '0 || overflow_o !== 1'b0) begin
      errs++; $display("FAIL rmid_async got v=%b cnt=%0d drop=%0d ovf=%b want all 0",
                       trc_valid_o, count_o, drop_cnt_o, overflow_o);
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    q.delete();
    pulse(32'h600, addi(5'd4, 12'd44), 32'd44, 32'h0, 32'h0, 1'b1);
    @(negedge clk_i);
    vecs++;
    if (trc_valid_o !== 1'b1 || head() !== q[0] || halt_o !== 1'b0) begin
      errs++; $display("FAIL rmid_run got v=%b halt=%b %h want v=1 halt=0 %h", trc_valid_o, halt_o, head(), q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_classify();
    test_overflow();
    test_backpressure();
    test_halt();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
